pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush scheduler for the 5-stage pipeline. Consumes decoded register usage from ID,

---
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: data-memory wait, redirect and load-use
// hazards, a wait-state FSM with sticky timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             mem_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             dmem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       WAIT_LIMIT = 8'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             dmem_timeout_q, dmem_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic mem_wait;
    logic redirect;
    logic rs_match;
    logic load_use;

    // Hazard classification, highest priority first; lower ones are masked.
    always_comb begin
        mem_wait = dmem_req & ~dmem_ready;
        redirect = mem_redirect & ~mem_wait;
        rs_match = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
        load_use = ex_is_load & (ex_rd != 5'd0) & rs_match & ~mem_wait & ~redirect;
    end

    always_comb begin
        pc_stall     = mem_wait | load_use;
        if_id_stall  = mem_wait | load_use;
        id_ex_stall  = mem_wait;
        ex_mem_stall = mem_wait;
        if_id_flush  = redirect;
        id_ex_flush  = redirect | load_use;
        ex_mem_flush = redirect;
        mem_wb_flush = mem_wait;
    end

    always_comb begin
        state_d        = mem_wait ? MEM_WAIT : RUN;
        wait_cnt_d     = 8'd0;
        dmem_timeout_d = dmem_timeout_q;
        if (state_q == MEM_WAIT && mem_wait) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt_q + 8'd1;
            if (wait_cnt_d == WAIT_LIMIT) begin
                dmem_timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_stall && stall_cycles_q != CNT_MAX) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (redirect && flush_events_q != CNT_MAX) begin
            flush_events_d = flush_events_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            dmem_timeout_q <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            dmem_timeout_q <= dmem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign dmem_timeout = dmem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios with literal expectations, then
// random stimulus checked every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int WT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_is_load;
    logic          mem_redirect, dmem_req, dmem_ready;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          dmem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_redirect(mem_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .dmem_timeout(dmem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    logic [7:0] dut_vec;
    assign dut_vec = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_in_wait;
    int m_waits;
    bit m_to;
    int m_stalls;
    int m_flushes;
    bit e_mw, e_redir, e_lu;
    logic [7:0] e_vec;

    always @(negedge clk) begin
        e_mw    = dmem_req && !dmem_ready;
        e_redir = mem_redirect && !e_mw;
        e_lu    = ex_is_load && (ex_rd != 0) && !e_mw && !e_redir &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_vec   = {e_mw || e_lu, e_mw || e_lu, e_mw, e_mw,
                   e_redir, e_redir || e_lu, e_redir, e_mw};
        if (rst) begin
            m_in_wait = 0; m_waits = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        end
        chk("ctrl_vec", dut_vec, e_vec);
        chk("timeout", dmem_timeout, m_to);
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("flush_events", flush_events, m_flushes);
        if (!rst) begin
            if (e_mw) begin
                if (m_in_wait) begin
                    if (m_waits < WT) m_waits++;
                    if (m_waits == WT) m_to = 1;
                end
                m_in_wait = 1;
            end else begin
                m_in_wait = 0;
                m_waits   = 0;
            end
            if (e_vec[7] && m_stalls < CMAX) m_stalls++;
            if (e_redir && m_flushes < CMAX) m_flushes++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_is_load = 0; mem_redirect = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_in();
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_cnt", stall_cycles, 0);
        chk("rst_flush_cnt", flush_events, 0);
        chk("rst_timeout", dmem_timeout, 0);
        chk("rst_vec", dut_vec, 8'h00);
        cyc();

        // load-use on rs2
        ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
        @(negedge clk);
        chk("lu_vec", dut_vec, 8'b1100_0100);
        cyc();
        idle_in();
        @(negedge clk);
        chk("lu_bubble_vec", dut_vec, 8'h00);
        chk("lu_stall_cnt", stall_cycles, 1);
        cyc();

        // x0 load is not a hazard
        ex_is_load = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0;
        @(negedge clk);
        chk("x0_pc_stall", pc_stall, 0);
        cyc();

        // taken branch masks a simultaneous load-use
        ex_is_load = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5; mem_redirect = 1;
        @(negedge clk);
        chk("br_vec", dut_vec, 8'b0000_1110);
        cyc();
        idle_in();
        @(negedge clk);
        chk("br_flush_cnt", flush_events, 1);
        chk("br_stall_cnt", stall_cycles, 1);
        cyc();

        // three-cycle data-memory wait
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_vec", dut_vec, 8'b1111_0001);
            cyc();
        end
        dmem_ready = 1;
        @(negedge clk);
        chk("ready_vec", dut_vec, 8'h00);
        cyc();
        idle_in();
        @(negedge clk);
        chk("wait3_stall_cnt", stall_cycles, 3);
        chk("wait3_timeout", dmem_timeout, 0);
        cyc();

        // timeout after the fourth cycle spent in MEM_WAIT
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) chk("to_before", dmem_timeout, 0);
            if (i == 6) chk("to_after", dmem_timeout, 1);
            cyc();
        end
        dmem_ready = 1;
        @(negedge clk);
        cyc();
        idle_in();
        mem_redirect = 1;
        @(negedge clk);
        chk("to_sticky", dmem_timeout, 1);
        chk("to_stall_cnt", stall_cycles, 6);
        cyc();
        idle_in();
        #1;
        rst = 1'b1;
        #1;
        chk("async_timeout", dmem_timeout, 0);
        chk("async_stall_cnt", stall_cycles, 0);
        chk("async_flush_cnt", flush_events, 0);
        cyc();
        rst = 1'b0;

        // stall counter saturation
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        repeat (20) cyc();
        @(negedge clk);
        chk("sat_stall_cnt", stall_cycles, CMAX);
        cyc();
        idle_in();

        // randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_is_load   = 1'($urandom_range(0, 1));
            mem_redirect = ($urandom_range(0, 5) == 0);
            dmem_req     = ($urandom_range(0, 2) != 0);
            dmem_ready   = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        idle_in();
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
